// File: rtl/fifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer
//  Brief    : Read-side consumer of an 8-bit async FIFO. Issues alternating
//             pops, absorbs the fixed read latency, packs bytes little-endian
//             into words and offers them on a valid/ready stream. A flush
//             pulse emits a partial word with a byte-keep mask.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                      rclk,
  input  logic                      rrst,
  input  logic                      fifo_empty,
  input  logic [DATA_W-1:0]         fifo_data,
  output logic                      fifo_r_en,
  input  logic                      flush,
  output logic [DATA_W*BYTES-1:0]   m_data,
  output logic [BYTES-1:0]          m_keep,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy
);

  localparam int CNT_W  = $clog2(BYTES + 1);
  localparam int SUM_W  = $clog2(BYTES + RD_LAT + 2);
  localparam int WORD_W = DATA_W * BYTES;

  logic                r_fifo_r_en;
  logic [RD_LAT-1:0]   r_pipe;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_asm;
  logic [WORD_W-1:0]   r_m_data;
  logic [BYTES-1:0]    r_m_keep;
  logic                r_m_valid;
  logic                r_flush_pend;

  logic [SUM_W-1:0]    w_inflight;
  logic [SUM_W-1:0]    w_sum;
  logic                w_land;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [WORD_W-1:0]   w_asm_nx;
  logic [BYTES-1:0]    w_keep_nx;
  logic                w_out_free;
  logic                w_full_move;
  logic                w_drained;
  logic                w_flush_move;
  logic                w_flush_done;
  logic                w_move;
  logic                w_pop;

  // Pops outstanding: the one being issued now plus those riding the latency pipe
  always_comb begin
    w_inflight = SUM_W'(r_fifo_r_en);
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + SUM_W'(r_pipe[i]);
    end
  end

  // Landing byte inserted into its slot, and the keep mask for the resulting fill level
  always_comb begin
    w_asm_nx  = r_asm;
    w_keep_nx = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (w_land && (CNT_W'(b) == r_cnt)) begin
        w_asm_nx[b*DATA_W +: DATA_W] = fifo_data;
      end
      w_keep_nx[b] = (CNT_W'(b) < w_cnt_nx);
    end
  end

  assign w_land     = r_pipe[RD_LAT-1];
  assign w_cnt_nx   = r_cnt + CNT_W'(w_land);
  assign w_sum      = SUM_W'(r_cnt) + w_inflight;
  assign w_out_free = !r_m_valid || m_ready;

  // A completed word moves on the very edge its last byte lands, if the output can take it
  assign w_full_move  = (w_cnt_nx == CNT_W'(BYTES)) && w_out_free;
  assign w_drained    = r_flush_pend && (w_inflight == '0);
  assign w_flush_move = w_drained && (r_cnt != '0) && w_out_free;
  assign w_flush_done = w_drained && ((r_cnt == '0) || w_out_free);
  assign w_move       = w_full_move || w_flush_move;

  // Issue every other cycle at most: the empty flag is one cycle stale after a pop
  assign w_pop = !fifo_empty && !r_fifo_r_en && (w_sum < SUM_W'(BYTES))
               && !r_flush_pend && !flush;

  // Latency pipe: the tail bit marks the cycle the popped byte is on fifo_data
  generate
    if (RD_LAT == 1) begin : g_pipe_single
      always_ff @(posedge rclk) begin
        if (rrst) r_pipe <= '0;
        else      r_pipe <= r_fifo_r_en;
      end
    end else begin : g_pipe_shift
      always_ff @(posedge rclk) begin
        if (rrst) r_pipe <= '0;
        else      r_pipe <= {r_pipe[RD_LAT-2:0], r_fifo_r_en};
      end
    end
  endgenerate

  // Pop request register
  always_ff @(posedge rclk) begin
    if (rrst) r_fifo_r_en <= 1'b0;
    else      r_fifo_r_en <= w_pop;
  end

  // Assembly buffer and byte count; cleared whenever a word leaves for the output
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_asm <= '0;
      r_cnt <= '0;
    end else if (w_move) begin
      r_asm <= '0;
      r_cnt <= '0;
    end else if (w_land) begin
      r_asm <= w_asm_nx;
      r_cnt <= w_cnt_nx;
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_move) begin
      r_m_data  <= w_asm_nx;
      r_m_keep  <= w_keep_nx;
      r_m_valid <= 1'b1;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Flush-pending flag; a new pulse while pending is ignored
  always_ff @(posedge rclk) begin
    if (rrst)              r_flush_pend <= 1'b0;
    else if (w_flush_done) r_flush_pend <= 1'b0;
    else if (flush)        r_flush_pend <= 1'b1;
  end

  assign fifo_r_en = r_fifo_r_en;
  assign m_data    = r_m_data;
  assign m_keep    = r_m_keep;
  assign m_valid   = r_m_valid;
  assign busy      = (r_cnt != '0) || (w_inflight != '0) || r_m_valid || r_flush_pend;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_packer
//  Brief    : Self-checking bench for fifo_rd_packer. A queue-based FIFO model
//             feeds the DUT; popped bytes are grouped into expected words and
//             compared against every accepted output word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

  localparam int DATA_W = 8;
  localparam int BYTES  = 4;
  localparam int RD_LAT = 2;

  logic        rclk       = 1'b0;
  logic        rrst       = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic        fifo_r_en;
  logic        flush      = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready    = 1'b0;
  logic        busy;

  fifo_rd_packer #(.DATA_W(DATA_W), .BYTES(BYTES), .RD_LAT(RD_LAT)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO + reference model ----------------
  logic [7:0]  src_q[$];    // bytes waiting in the FIFO
  logic [7:0]  pend_q[$];   // popped bytes not yet part of an expected word
  logic [35:0] exp_q[$];    // expected {keep, data}
  logic [7:0]  d1 = 8'h00;
  int          cyc = 0;

  always @(posedge rclk) begin
    logic [7:0]  b;
    logic [31:0] w;
    b = 8'h00;
    cyc++;
    if (fifo_r_en) begin
      check_val("pop_underflow", 32'(src_q.size() != 0), 32'd1);
      if (src_q.size() != 0) b = src_q.pop_front();
      pend_q.push_back(b);
      d1 <= b;
    end
    fifo_data <= d1;
    if (pend_q.size() == BYTES) begin
      w = '0;
      for (int i = 0; i < BYTES; i++) w[8*i +: 8] = pend_q[i];
      exp_q.push_back({4'hF, w});
      pend_q.delete();
    end
    if (flush && !rrst) begin
      if (pend_q.size() != 0) begin
        w = '0;
        for (int i = 0; i < pend_q.size(); i++) w[8*i +: 8] = pend_q[i];
        exp_q.push_back({4'((1 << pend_q.size()) - 1), w});
      end
      pend_q.delete();
    end
    if (rrst) begin
      src_q.delete();
      pend_q.delete();
      exp_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      fifo_empty <= (src_q.size() == 0);
    end
  end

  // ---------------- output monitor / scoreboard ----------------
  logic        prev_hold  = 1'b0;
  logic [31:0] prev_data  = '0;
  logic [3:0]  prev_keep  = '0;
  logic        prev_ren   = 1'b0;
  logic        prev_empty = 1'b1;
  logic        prev_valid = 1'b0;
  int          ren_cyc[$];
  int          vrise_cyc[$];
  int          acc_cyc[$];
  logic [35:0] acc_q[$];

  always @(negedge rclk) begin
    logic [35:0] e;
    if (rrst) begin
      prev_hold  = 1'b0;
      prev_ren   = 1'b0;
      prev_valid = 1'b0;
      prev_empty = fifo_empty;
    end else begin
      if (prev_hold) begin
        check_val("hold_valid", 32'(m_valid), 32'd1);
        check_val("hold_data", m_data, prev_data);
        check_val("hold_keep", 32'(m_keep), 32'(prev_keep));
      end
      if (fifo_r_en) begin
        ren_cyc.push_back(cyc);
        check_val("ren_back_to_back", 32'(prev_ren), 32'd0);
        check_val("ren_while_empty", 32'(prev_empty), 32'd0);
      end
      if (m_valid && !prev_valid) vrise_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        acc_q.push_back({m_keep, m_data});
        acc_cyc.push_back(cyc);
        check_val("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("sb_data", m_data, e[31:0]);
          check_val("sb_keep", 32'(m_keep), 32'(e[35:32]));
        end
      end
      prev_hold  = m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
      prev_ren   = fifo_r_en;
      prev_empty = fifo_empty;
      prev_valid = m_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic clear_obs();
    ren_cyc.delete();
    vrise_cyc.delete();
    acc_cyc.delete();
    acc_q.delete();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
  endtask

  initial begin
    int k;
    // ---- reset then idle ----
    step(2);
    @(negedge rclk);
    check_val("rst_ren", 32'(fifo_r_en), 32'd0);
    check_val("rst_valid", 32'(m_valid), 32'd0);
    check_val("rst_data", m_data, 32'd0);
    check_val("rst_keep", 32'(m_keep), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    step(1);
    rrst = 1'b0;
    clear_obs();
    step(10);
    check_val("idle_no_pop", 32'(ren_cyc.size()), 32'd0);
    check_val("idle_busy", 32'(busy), 32'd0);

    // ---- steady stream ----
    m_ready = 1'b1;
    clear_obs();
    src_q.push_back(8'h11); src_q.push_back(8'h22);
    src_q.push_back(8'h33); src_q.push_back(8'h44);
    step(20);
    check_val("stream_pops", 32'(ren_cyc.size()), 32'd4);
    for (int i = 1; i < ren_cyc.size(); i++)
      check_val("stream_pop_gap", 32'(ren_cyc[i] - ren_cyc[i-1]), 32'd2);
    check_val("stream_vrise", 32'(vrise_cyc.size()), 32'd1);
    if (vrise_cyc.size() >= 1 && ren_cyc.size() >= 4)
      check_val("stream_latency", 32'(vrise_cyc[0] - ren_cyc[3]), 32'(RD_LAT + 1));
    check_val("stream_words", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) begin
      check_val("stream_data", acc_q[0][31:0], 32'h44332211);
      check_val("stream_keep", 32'(acc_q[0][35:32]), 32'hF);
    end
    check_val("stream_busy", 32'(busy), 32'd0);

    // ---- backpressure ----
    m_ready = 1'b0;
    clear_obs();
    for (int i = 1; i <= 12; i++) src_q.push_back(8'(i));
    step(40);
    check_val("bp_pops", 32'(ren_cyc.size()), 32'd8);
    check_val("bp_valid", 32'(m_valid), 32'd1);
    check_val("bp_data", m_data, 32'h04030201);
    check_val("bp_keep", 32'(m_keep), 32'hF);
    m_ready = 1'b1;
    step(30);
    check_val("bp_words", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 2) begin
      check_val("bp_word0", acc_q[0][31:0], 32'h04030201);
      check_val("bp_word1", acc_q[1][31:0], 32'h08070605);
      check_val("bp_consecutive", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    end

    // ---- flush partial, then flush with nothing assembled ----
    clear_obs();
    src_q.push_back(8'hAA); src_q.push_back(8'hBB); src_q.push_back(8'hCC);
    step(12);
    pulse_flush();
    step(12);
    check_val("flush_words", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) begin
      check_val("flush_data", acc_q[0][31:0], 32'h00CCBBAA);
      check_val("flush_keep", 32'(acc_q[0][35:32]), 32'h7);
    end
    check_val("flush_busy", 32'(busy), 32'd0);
    clear_obs();
    pulse_flush();
    step(10);
    check_val("flush_empty_novalid", 32'(vrise_cyc.size()), 32'd0);

    // ---- empty mid-word ----
    clear_obs();
    src_q.push_back(8'h9A); src_q.push_back(8'hBC);
    step(12);
    check_val("midword_pops", 32'(ren_cyc.size()), 32'd2);
    check_val("midword_ren", 32'(fifo_r_en), 32'd0);
    check_val("midword_busy", 32'(busy), 32'd1);
    check_val("midword_novalid", 32'(vrise_cyc.size()), 32'd0);
    src_q.push_back(8'hDE); src_q.push_back(8'hF0);
    step(12);
    check_val("midword_words", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) check_val("midword_data", acc_q[0][31:0], 32'hF0DEBC9A);

    // ---- reset mid-operation ----
    m_ready = 1'b0;
    clear_obs();
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h21 + i));
    k = 0;
    while (!m_valid && k < 40) begin step(1); k++; end
    check_val("rstmid_wait_valid", 32'(m_valid), 32'd1);
    src_q.push_back(8'h25); src_q.push_back(8'h26); src_q.push_back(8'h27);
    k = 0;
    while (ren_cyc.size() < 6 && k < 40) begin step(1); k++; end
    check_val("rstmid_wait_pops", 32'(ren_cyc.size() >= 6), 32'd1);
    rrst = 1'b1;
    step(1);
    check_val("rstmid_valid", 32'(m_valid), 32'd0);
    check_val("rstmid_busy", 32'(busy), 32'd0);
    rrst = 1'b0;
    m_ready = 1'b1;
    clear_obs();
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h31 + i));
    step(20);
    check_val("rstmid_words", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() >= 1) check_val("rstmid_data", acc_q[0][31:0], 32'h34333231);

    // ---- randomized traffic with backpressure and occasional flush ----
    clear_obs();
    for (int it = 0; it < 3000; it++) begin
      if (src_q.size() < 8 && $urandom_range(0, 99) < 40)
        src_q.push_back(8'($urandom_range(0, 255)));
      m_ready = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 199) == 0) begin
        pulse_flush();
        m_ready = 1'b1;
        step(10);
      end else begin
        step(1);
      end
    end
    m_ready = 1'b1;
    step(40);
    pulse_flush();
    step(20);
    check_val("rand_words_seen", 32'(acc_q.size() > 20), 32'd1);
    check_val("rand_drained", 32'(exp_q.size()), 32'd0);
    check_val("rand_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the 8-bit asynchronous FIFO, running in the read clock domain.
- Issues pops against the FIFO's registered `data_out` / `empty` outputs and absorbs the fixed read latency.
- Packs bytes little-endian into 32-bit words and presents them on a valid/ready stream to the next stage.
- An optional flush emits a partial word with a byte-keep mask.

Parameters:
- DATA_W, 8, FIFO byte width; fixed at 8.
- BYTES, 4, bytes per output word; output width is DATA_W*BYTES.
- RD_LAT, 2, cycles from `fifo_r_en` high to the corresponding byte valid on `fifo_data`.

Ports:
- rclk  input  1  read-domain clock; all logic on its rising edge.
- rrst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, registered, may lag true state by 1 cycle.
- fifo_data  input  8  FIFO `data_out`.
- fifo_r_en  output  1  pop request to the FIFO.
- flush  input  1  one-cycle pulse: emit the partially filled word once all in-flight bytes land.
- m_data  output  32  packed word; byte 0 in bits [7:0].
- m_keep  output  4  byte-valid mask; 4'b1111 for full words.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- busy  output  1  high when any byte is assembled, in flight, or held in the output register.

Behaviour:
- Interface: one clock (`rclk`); reset `rrst` is synchronous and active-high.
- Reset (`rrst`=1 sampled at a rising edge):
  - `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `m_keep`=0, `busy`=0.
  - Assembly count, in-flight pipe and flush-pending flag all clear.
  - Bytes in flight at reset are discarded; reset overrides all other inputs that cycle.
- Pop issue:
  - `fifo_r_en` is registered.
  - It asserts in a cycle only if all of the following hold:
    - `fifo_empty`=0 sampled that cycle;
    - `fifo_r_en` was 0 in the previous cycle;
    - assembled count + in-flight count < BYTES;
    - no flush is pending.
  - Alternating issue is mandatory: it covers the 1-cycle stale empty. Maximum rate is 1 byte per 2 cycles.
- Latency tracking:
  - A RD_LAT-deep shift register carries each issued pop.
  - When its tail bit is 1, `fifo_data` is captured into byte slot [count] and the count increments.
- Word completion: when the count reaches BYTES, move the assembled word to the output register if it is empty, or being accepted that cycle (`m_valid` & `m_ready`).
  - On move: `m_keep`=4'b1111, count resets to 0.
  - Otherwise the assembly stalls at BYTES. No further pops issue, because count + in-flight ≥ BYTES.
- Output handshake:
  - `m_valid` stays high and `m_data` / `m_keep` stay stable until `m_ready`=1.
  - Back-to-back transfers are allowed: a new word may load in the same cycle the held word is accepted.
- Flush:
  - A `flush` pulse sets flush_pending and stops new pops.
  - Once in-flight = 0:
    - if count > 0, the partial word moves to the output register with `m_keep` = (1<<count)-1; unused bytes are 0;
    - if count = 0, no word is produced.
  - flush_pending then clears.
  - A flush arriving while flush_pending is set is ignored.
- Simultaneous events:
  - A byte landing in the same cycle as a word move lands in slot 0 of the new word.
  - This cannot occur at count = BYTES.
- `busy` = (count ≠ 0) | (in-flight ≠ 0) | `m_valid` | flush_pending.

Test Plan:
- Reset then idle: `rrst`=1 for 2 cycles, `fifo_empty`=1 → all outputs 0, `fifo_r_en` never asserts.
- Steady stream: FIFO supplies 0x11,0x22,0x33,0x44, `m_ready`=1 → `fifo_r_en` toggles 1,0,1,0 and `m_data`=0x44332211, `m_keep`=4'hF. `m_valid` rises exactly RD_LAT+1 cycles after the 4th pop.
- Backpressure: 8 bytes 0x01..0x08 with `m_ready`=0 → first word 0x04030201 held stable and pops stop after 8 in total. Raising `m_ready` yields 0x04030201 then 0x08070605 on consecutive accepts.
- Flush partial: 3 bytes 0xAA,0xBB,0xCC, then `flush` pulse → `m_data`=0x00CCBBAA, `m_keep`=4'b0111; a flush with count=0 → no `m_valid`.
- Empty mid-word: `fifo_empty` rises after 2 bytes → `fifo_r_en` stays 0 and `busy`=1 with no output. Refilling completes the word with correct byte order.
- Reset mid-operation: `rrst` pulsed with 2 bytes in flight and a word held → next cycle `m_valid`=0 and `busy`=0. Subsequent data packs from slot 0.
